// File: rtl/green_blob_tracker.sv
// Per-frame green blob statistics: run-filtered pixel count and bounding box,
// published once per frame with a one-cycle blob_valid pulse.
module green_blob_tracker #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned MIN_RUN   = 4,
  parameter int unsigned MIN_COUNT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        greencheck,
  output logic        blob_valid,
  output logic        blob_found,
  output logic [18:0] green_count,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max
);

  localparam int unsigned CW = 19;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned XW = 10;
  localparam int unsigned RW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {WAIT_SOF, ACCUM, REPORT} state_e;

  state_e          state_q, state_d;
  logic            pv_q;
  logic [XW-1:0]   x_q, y_q;
  logic [RW-1:0]   run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            have_q, have_d;
  logic [XW-1:0]   axmn_q, axmn_d, axmx_q, axmx_d, aymn_q, aymn_d, aymx_q, aymx_d;
  logic            bv_q, bv_d, found_q, found_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic [XW-1:0]   oxmn_q, oxmn_d, oxmx_q, oxmx_d, oymn_q, oymn_d, oymx_q, oymx_d;

  logic            sof, eof, process, clear_base, upd;
  logic [RW-1:0]   run_b;
  logic [CW-1:0]   cnt_b;
  logic            have_b;
  logic [XW-1:0]   bxmn, bxmx, bymn, bymx, left;
  logic [RW-1:0]   add;
  logic [SW-1:0]   sum;

  // Delay the pixel qualifiers by one cycle so they line up with greencheck.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      pv_q <= pix_valid;
      x_q  <= x_in;
      y_q  <= y_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SOF;
      run_q   <= '0;
      cnt_q   <= '0;
      have_q  <= 1'b0;
      axmn_q  <= '0;
      axmx_q  <= '0;
      aymn_q  <= '0;
      aymx_q  <= '0;
      bv_q    <= 1'b0;
      found_q <= 1'b0;
      ocnt_q  <= '0;
      oxmn_q  <= '0;
      oxmx_q  <= '0;
      oymn_q  <= '0;
      oymx_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      have_q  <= have_d;
      axmn_q  <= axmn_d;
      axmx_q  <= axmx_d;
      aymn_q  <= aymn_d;
      aymx_q  <= aymx_d;
      bv_q    <= bv_d;
      found_q <= found_d;
      ocnt_q  <= ocnt_d;
      oxmn_q  <= oxmn_d;
      oxmx_q  <= oxmx_d;
      oymn_q  <= oymn_d;
      oymx_q  <= oymx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    cnt_d      = cnt_q;
    have_d     = have_q;
    axmn_d     = axmn_q;
    axmx_d     = axmx_q;
    aymn_d     = aymn_q;
    aymx_d     = aymx_q;
    bv_d       = 1'b0;
    found_d    = found_q;
    ocnt_d     = ocnt_q;
    oxmn_d     = oxmn_q;
    oxmx_d     = oxmx_q;
    oymn_d     = oymn_q;
    oymx_d     = oymx_q;
    process    = 1'b0;
    clear_base = 1'b0;
    upd        = 1'b0;
    add        = '0;
    left       = x_q;
    sum        = '0;

    sof = pv_q && (x_q == '0) && (y_q == '0);
    eof = pv_q && (x_q == XW'(H_ACTIVE - 1)) && (y_q == XW'(V_ACTIVE - 1));

    case (state_q)
      WAIT_SOF: begin
        if (sof) begin
          process    = 1'b1;
          clear_base = 1'b1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (pv_q) begin
          process    = 1'b1;
          clear_base = sof;
          if (eof) state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = WAIT_SOF;
        run_d   = '0;
        cnt_d   = '0;
        have_d  = 1'b0;
        axmn_d  = '0;
        axmx_d  = '0;
        aymn_d  = '0;
        aymx_d  = '0;
      end
      default: state_d = WAIT_SOF;
    endcase

    // A start-of-frame pixel processes against freshly cleared accumulators.
    run_b  = clear_base ? '0   : run_q;
    cnt_b  = clear_base ? '0   : cnt_q;
    have_b = clear_base ? 1'b0 : have_q;
    bxmn   = clear_base ? '0   : axmn_q;
    bxmx   = clear_base ? '0   : axmx_q;
    bymn   = clear_base ? '0   : aymn_q;
    bymx   = clear_base ? '0   : aymx_q;
    if (x_q == '0) run_b = '0;

    if (process) begin
      if (greencheck) begin
        if (run_b == RW'(MIN_RUN - 1)) begin
          run_d = RW'(MIN_RUN);
          add   = RW'(MIN_RUN);
          upd   = 1'b1;
          left  = x_q - XW'(MIN_RUN - 1);
        end else if (run_b == RW'(MIN_RUN)) begin
          run_d = run_b;
          add   = RW'(1);
          upd   = 1'b1;
        end else begin
          run_d = run_b + RW'(1);
        end
      end else begin
        run_d = '0;
      end

      sum   = SW'(cnt_b) + SW'(add);
      cnt_d = sum[CW] ? CNT_MAX : sum[CW-1:0];

      have_d = have_b | upd;
      axmn_d = bxmn;
      axmx_d = bxmx;
      aymn_d = bymn;
      aymx_d = bymx;
      if (upd) begin
        if (!have_b) begin
          axmn_d = left;
          axmx_d = x_q;
          aymn_d = y_q;
          aymx_d = y_q;
        end else begin
          if (left < bxmn) axmn_d = left;
          if (x_q > bxmx)  axmx_d = x_q;
          if (y_q < bymn)  aymn_d = y_q;
          if (y_q > bymx)  aymx_d = y_q;
        end
      end

      // Last pixel: publish including its own contribution so the pulse lands in REPORT.
      if (eof) begin
        bv_d    = 1'b1;
        found_d = (cnt_d >= CW'(MIN_COUNT));
        ocnt_d  = cnt_d;
        oxmn_d  = axmn_d;
        oxmx_d  = axmx_d;
        oymn_d  = aymn_d;
        oymx_d  = aymx_d;
      end
    end
  end

  assign blob_valid  = bv_q;
  assign blob_found  = found_q;
  assign green_count = ocnt_q;
  assign x_min       = oxmn_q;
  assign x_max       = oxmx_q;
  assign y_min       = oymn_q;
  assign y_max       = oymx_q;

endmodule

// File: tb/tb_green_blob_tracker.sv
// Directed frame-level checks of green_blob_tracker on a reduced 64x48 raster.
module tb_green_blob_tracker;

  localparam int H = 64;
  localparam int V = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  x_in = '0;
  logic [9:0]  y_in = '0;
  logic        greencheck = 1'b0;
  logic        blob_valid, blob_found;
  logic [18:0] green_count;
  logic [9:0]  x_min, x_max, y_min, y_max;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int last_cyc = 0;
  logic g_prev = 1'b0;

  always #5 clk = ~clk;

  green_blob_tracker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MIN_RUN(4), .MIN_COUNT(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x_in(x_in), .y_in(y_in),
    .greencheck(greencheck), .blob_valid(blob_valid), .blob_found(blob_found),
    .green_count(green_count), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (blob_valid) begin
      pulses    = pulses + 1;
      pulse_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic green(input int mode, input int x, input int y);
    case (mode)
      1: return (x >= 10 && x <= 19 && y >= 20 && y <= 39);
      2: return ((x % 10) >= 5 && (x % 10) <= 7);
      3: return ((x % 10) >= 5 && (x % 10) <= 7) || (y == 5 && x >= 10 && x <= 13);
      4: return (y == 7 && x >= 60) || (y == 8 && x <= 2);
      5: return 1'b1;
      6: return (x >= 10 && x <= 19 && y >= 20 && y <= 38);
      default: return 1'b0;
    endcase
  endfunction

  // One cycle on the pixel bus; greencheck trails its pixel by one cycle.
  task automatic step(input logic v, input int x, input int y, input logic g);
    @(negedge clk);
    pix_valid  = v;
    x_in       = 10'(x);
    y_in       = 10'(y);
    greencheck = g_prev;
    g_prev     = v & g;
    if (v && x == H - 1 && y == V - 1) last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0);
  endtask

  // Drive a frame; stops before pixel (stop_x, stop_y) when that lies inside the raster.
  task automatic frame(input int mode, input int stop_y, input int stop_x);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y == stop_y && x == stop_x) return;
        step(1'b1, x, y, green(mode, x, y));
      end
      idle(2);
    end
  endtask

  task automatic expect_frame(input string tag, input int p0, input int cnt, input int xmn,
                              input int xmx, input int ymn, input int ymx, input int found);
    idle(6);
    chk({tag, ".pulses"}, pulses - p0, 1);
    chk({tag, ".latency"}, pulse_cyc - last_cyc, 2);
    chk({tag, ".count"}, int'(green_count), cnt);
    chk({tag, ".x_min"}, int'(x_min), xmn);
    chk({tag, ".x_max"}, int'(x_max), xmx);
    chk({tag, ".y_min"}, int'(y_min), ymn);
    chk({tag, ".y_max"}, int'(y_max), ymx);
    chk({tag, ".found"}, int'(blob_found), found);
    chk({tag, ".valid_low"}, int'(blob_valid), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, int'(blob_valid), 0);
    chk({tag, ".found"}, int'(blob_found), 0);
    chk({tag, ".count"}, int'(green_count), 0);
    chk({tag, ".bbox"}, int'({x_min, x_max, y_min, y_max}), 0);
  endtask

  int p0;

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(3);

    p0 = pulses; frame(0, V, 0);
    expect_frame("dark", p0, 0, 0, 0, 0, 0, 0);

    p0 = pulses; frame(1, V, 0);
    expect_frame("block200", p0, 200, 10, 19, 20, 39, 1);

    p0 = pulses; frame(6, V, 0);
    expect_frame("block190", p0, 190, 10, 19, 20, 38, 0);

    p0 = pulses; frame(2, V, 0);
    expect_frame("runs3", p0, 0, 0, 0, 0, 0, 0);

    p0 = pulses; frame(3, V, 0);
    expect_frame("runs3_plus4", p0, 4, 10, 13, 5, 5, 0);

    p0 = pulses; frame(4, V, 0);
    expect_frame("line_wrap", p0, 4, 60, 63, 7, 7, 0);

    p0 = pulses; frame(5, 24, 31);
    frame(1, V, 0);
    expect_frame("restart", p0, 200, 10, 19, 20, 39, 1);

    // Asynchronous reset midway through a frame clears outputs before the next edge.
    p0 = pulses; frame(5, 30, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    g_prev = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    frame(3, V, 0);
    expect_frame("after_rst", p0, 4, 10, 13, 5, 5, 0);

    p0 = pulses; frame(5, V, 0);
    expect_frame("full", p0, H * V, 0, H - 1, 0, V - 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
